// File: rtl/amiga_clk_pkg.sv
// Shared definitions for the Amiga clock-generation blocks.
//   pll_seq_state_t : states of the PLL reconfiguration sequencer
//   DEF_*           : default timeouts / retry limit for the sequencer
//   timer_width()   : width of an unsigned down-counter able to hold the
//                     larger of two timeout values
package amiga_clk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_WAIT,
    WAIT_BUSY,
    RECONF,
    RUN,
    LOCK,
    FAIL
  } pll_seq_state_t;

  localparam int DEF_RECONF_TIMEOUT = 1000;
  localparam int DEF_LOCK_TIMEOUT   = 4096;
  localparam int DEF_MAX_RETRIES    = 2;

  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/amiga_sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset (output returns to 0)
//   d   : asynchronous input
//   q   : input re-timed to clk, two flops of latency
module amiga_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/amiga_pll_reconfig_seq.sv
// PAL/NTSC switching sequencer for the Amiga clock PLL.
// Watches the synchronised mode request and, when it differs from the mode
// programmed into the PLL, drives the reconfig core through ROM load,
// reconfig and re-lock, holding the downstream clock generators off
// (sys_hold) until the new clocks are stable.
//
// Optional feature: define MINIMIG_PLL_RECONFIG_RETRY_EN to retry a failed
// sequence (RUN or LOCK timeout) up to MAX_RETRIES times before reporting
// err. Without it a timeout goes straight to FAIL.
//
// Ports:
//   clk_in         : reconfig clock (27 MHz board input)
//   rst            : asynchronous active-high reset
//   ntsc           : requested mode, 1 = NTSC (asynchronous)
//   pll_locked     : PLL lock (asynchronous)
//   busy           : reconfig core busy
//   write_from_rom : 1-cycle pulse, start ROM -> scan chain load
//   reconfig       : 1-cycle pulse, apply scan chain
//   reconfig_reset : 1-cycle pulse, reset a stuck reconfig core
//   rom_sel_ntsc   : ROM image select, held for the whole sequence
//   cur_ntsc       : mode currently programmed into the PLL
//   sys_hold       : hold request for the generated-clock logic
//   done           : 1-cycle pulse, sequence completed with lock
//   err            : sticky failure flag, cleared by rst or next done
module amiga_pll_reconfig_seq
  import amiga_clk_pkg::*;
#(
  parameter int RECONF_TIMEOUT = DEF_RECONF_TIMEOUT,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic clk_in,
  input  logic rst,
  input  logic ntsc,
  input  logic pll_locked,
  input  logic busy,
  output logic write_from_rom,
  output logic reconfig,
  output logic reconfig_reset,
  output logic rom_sel_ntsc,
  output logic cur_ntsc,
  output logic sys_hold,
  output logic done,
  output logic err
);

  localparam int TMR_W = timer_width(RECONF_TIMEOUT, LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] T_RECONF = TMR_W'(RECONF_TIMEOUT);
  localparam logic [TMR_W-1:0] T_LOCK   = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);

  // A timer that is loaded with less than 2 would expire on its load value.
  if (RECONF_TIMEOUT < 2 || LOCK_TIMEOUT < 2 || MAX_RETRIES < 0) begin : g_param_check
    $error("amiga_pll_reconfig_seq: timeouts must be >= 2, MAX_RETRIES >= 0");
  end

  logic ntsc_s;
  logic locked_s;

  amiga_sync2 u_sync_ntsc (
    .clk (clk_in),
    .rst (rst),
    .d   (ntsc),
    .q   (ntsc_s)
  );

  amiga_sync2 u_sync_locked (
    .clk (clk_in),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  pll_seq_state_t state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt, timer_dec;
  logic wfr_nxt, reconfig_nxt, rr_nxt, done_nxt;
  logic rom_sel_nxt, cur_nxt, hold_nxt, err_nxt;
  logic fail_req;

`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
`endif

  // Saturating decrement: the timer parks at 1 and never wraps.
  assign timer_dec = (timer > T_ONE) ? timer - T_ONE : timer;

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    wfr_nxt      = 1'b0;
    reconfig_nxt = 1'b0;
    rr_nxt       = 1'b0;
    done_nxt     = 1'b0;
    rom_sel_nxt  = rom_sel_ntsc;
    cur_nxt      = cur_ntsc;
    err_nxt      = err;
    hold_nxt     = 1'b1;
    fail_req     = 1'b0;
`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
    retry_nxt    = retry_cnt;
`endif

    case (state)
      IDLE: begin
`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
        retry_nxt = '0;
`endif
        if (ntsc_s != cur_ntsc) begin
          rom_sel_nxt = ntsc_s;
          wfr_nxt     = 1'b1;
          state_nxt   = LOAD;
        end else begin
          hold_nxt = ~locked_s;
        end
      end
      LOAD:      state_nxt = LOAD_WAIT;
      LOAD_WAIT: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        // A core that is already busy here is waited on indefinitely; only
        // the RUN timeout covers a stuck core.
        if (!busy) begin
          reconfig_nxt = 1'b1;
          timer_nxt    = T_RECONF;
          state_nxt    = RECONF;
        end
      end
      RECONF:    state_nxt = RUN;
      RUN: begin
        timer_nxt = timer_dec;
        if (!busy) begin
          timer_nxt = T_LOCK;
          state_nxt = LOCK;
        end else if (timer_dec == T_ONE) begin
          rr_nxt   = 1'b1;
          fail_req = 1'b1;
        end
      end
      LOCK: begin
        timer_nxt = timer_dec;
        if (locked_s) begin
          cur_nxt   = rom_sel_ntsc;
          done_nxt  = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (timer_dec == T_ONE) begin
          fail_req = 1'b1;
        end
      end
      FAIL: begin
        // cur_ntsc is untouched, so IDLE retries at once if still requested.
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (fail_req) begin
`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
      if (retry_cnt < RETRY_MAX) begin
        // Retry restarts at the ROM load with the same image, resetting the
        // core on the way (RUN has already requested this reset).
        retry_nxt = retry_cnt + RETRY_ONE;
        rr_nxt    = 1'b1;
        wfr_nxt   = 1'b1;
        state_nxt = LOAD;
      end else begin
        state_nxt = FAIL;
      end
`else
      state_nxt = FAIL;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      write_from_rom <= 1'b0;
      reconfig       <= 1'b0;
      reconfig_reset <= 1'b0;
      done           <= 1'b0;
      rom_sel_ntsc   <= 1'b0;
      cur_ntsc       <= 1'b0;
      sys_hold       <= 1'b1;
      err            <= 1'b0;
`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
      retry_cnt      <= '0;
`endif
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      write_from_rom <= wfr_nxt;
      reconfig       <= reconfig_nxt;
      reconfig_reset <= rr_nxt;
      done           <= done_nxt;
      rom_sel_ntsc   <= rom_sel_nxt;
      cur_ntsc       <= cur_nxt;
      sys_hold       <= hold_nxt;
      err            <= err_nxt;
`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
      retry_cnt      <= retry_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_amiga_pll_reconfig_seq.sv
// Directed testbench for amiga_pll_reconfig_seq (default parameters).
// Expectations that depend on MINIMIG_PLL_RECONFIG_RETRY_EN follow the macro.
module tb_amiga_pll_reconfig_seq;

  logic clk_in = 1'b0;
  logic rst, ntsc, pll_locked, busy, stuck;
  logic write_from_rom, reconfig, reconfig_reset, rom_sel_ntsc;
  logic cur_ntsc, sys_hold, done, err;

  int n_chk = 0;
  int n_bad = 0;
  int wfr_t, rc_t, rr_t, done_t;
  int busy_cnt;
  bit ok;
  int cyc;

`ifdef MINIMIG_PLL_RECONFIG_RETRY_EN
  localparam int EXP_WFR_TO_ERR = 3;
  localparam int EXP_ERR_AFTER_RR = 0;
`else
  localparam int EXP_WFR_TO_ERR = 1;
  localparam int EXP_ERR_AFTER_RR = 1;
`endif

  always #5 clk_in = ~clk_in;

  amiga_pll_reconfig_seq dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .ntsc           (ntsc),
    .pll_locked     (pll_locked),
    .busy           (busy),
    .write_from_rom (write_from_rom),
    .reconfig       (reconfig),
    .reconfig_reset (reconfig_reset),
    .rom_sel_ntsc   (rom_sel_ntsc),
    .cur_ntsc       (cur_ntsc),
    .sys_hold       (sys_hold),
    .done           (done),
    .err            (err)
  );

  // Reconfig core model: busy rises after reconfig, drops 20 cycles later
  // unless stuck; reconfig_reset always clears it.
  initial begin
    busy = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk_in);
      if (reconfig_reset) begin
        busy = 1'b0;
        busy_cnt = 0;
      end else if (reconfig) begin
        busy = 1'b1;
        busy_cnt = 20;
      end else if (busy && !stuck) begin
        busy_cnt--;
        if (busy_cnt == 0) busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; sample 1 ns after each edge and tally pulses.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      wfr_t  += int'(write_from_rom);
      rc_t   += int'(reconfig);
      rr_t   += int'(reconfig_reset);
      done_t += int'(done);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0: return write_from_rom;
      1: return reconfig;
      2: return reconfig_reset;
      3: return done;
      default: return err;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, output bit found, output int cycles);
    found = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      step(1);
      cycles++;
      if (pick(which)) found = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    ntsc = 1'b0;
    pll_locked = 1'b1;
    stuck = 1'b0;
    wfr_t = 0; rc_t = 0; rr_t = 0; done_t = 0;

    // Reset state
    step(3);
    chk("rst_sys_hold", sys_hold, 1);
    chk("rst_cur_ntsc", cur_ntsc, 0);
    chk("rst_rom_sel", rom_sel_ntsc, 0);
    chk("rst_pulses", {write_from_rom, reconfig, reconfig_reset, done, err}, 0);
    rst = 1'b0;
    step(2);
    chk("hold_after_2", sys_hold, 1);
    step(1);
    chk("hold_after_3", sys_hold, 0);
    step(10);
    chk("idle_no_pulses", wfr_t + rc_t + rr_t + done_t, 0);
    chk("idle_cur_ntsc", cur_ntsc, 0);

    // PAL -> NTSC, normal completion
    ntsc = 1'b1;
    step(2);
    chk("wfr_early", write_from_rom, 0);
    step(1);
    chk("wfr_at_3", write_from_rom, 1);
    chk("rom_sel_latched", rom_sel_ntsc, 1);
    chk("hold_in_seq", sys_hold, 1);
    step(2);
    chk("reconfig_early", reconfig, 0);
    step(1);
    chk("reconfig_at_6", reconfig, 1);
    pll_locked = 1'b0;
    done_t = 0;
    step(50);
    chk("no_done_unlocked", done_t, 0);
    pll_locked = 1'b1;
    step(2);
    chk("done_early", done, 0);
    step(1);
    chk("done_pulse", done, 1);
    chk("cur_ntsc_on_done", cur_ntsc, 1);
    chk("hold_on_done", sys_hold, 1);
    step(1);
    chk("hold_released", sys_hold, 0);
    step(10);
    chk("done_once", done_t, 1);
    chk("err_clean", err, 0);

    // NTSC -> PAL with busy stuck high
    wfr_t = 0;
    ntsc = 1'b0;
    stuck = 1'b1;
    step(3);
    chk("stuck_wfr", write_from_rom, 1);
    step(3);
    chk("stuck_reconfig", reconfig, 1);
    step(999);
    chk("rr_early", reconfig_reset, 0);
    step(1);
    chk("rr_at_999", reconfig_reset, 1);
    step(1);
    chk("err_after_rr", err, EXP_ERR_AFTER_RR);
    if (!err) begin
      wait_for(4, 8000, ok, cyc);
      chk("err_rises", ok, 1);
    end
    chk("wfr_before_err", wfr_t, EXP_WFR_TO_ERR);
    wait_for(0, 5, ok, cyc);
    chk("restart_after_fail", ok, 1);
    chk("restart_latency", cyc, 1);
    stuck = 1'b0;
    wait_for(3, 300, ok, cyc);
    chk("recover_done", ok, 1);
    chk("recover_cur_ntsc", cur_ntsc, 0);
    chk("err_cleared", err, 0);
    step(5);

    // Mode toggles back during RUN
    ntsc = 1'b1;
    wait_for(1, 20, ok, cyc);
    chk("toggle_reconfig", ok, 1);
    step(5);
    ntsc = 1'b0;
    step(3);
    chk("rom_sel_held", rom_sel_ntsc, 1);
    wait_for(3, 200, ok, cyc);
    chk("toggle_done", ok, 1);
    chk("toggle_cur_ntsc", cur_ntsc, 1);
    chk("toggle_rom_sel", rom_sel_ntsc, 1);
    step(1);
    chk("second_seq_wfr", write_from_rom, 1);
    chk("second_seq_rom_sel", rom_sel_ntsc, 0);
    wait_for(3, 200, ok, cyc);
    chk("second_done", ok, 1);
    chk("second_cur_ntsc", cur_ntsc, 0);
    step(5);

    // Reset asserted in LOCK
    ntsc = 1'b1;
    wait_for(1, 20, ok, cyc);
    chk("lock_reconfig", ok, 1);
    pll_locked = 1'b0;
    step(25);
    chk("lock_hold", sys_hold, 1);
    done_t = 0;
    wfr_t = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_hold", sys_hold, 1);
    chk("mid_rst_cur", cur_ntsc, 0);
    chk("mid_rst_pulses", {write_from_rom, reconfig, reconfig_reset, done}, 0);
    step(3);
    pll_locked = 1'b1;
    rst = 1'b0;
    step(2);
    chk("post_rst_wfr_early", write_from_rom, 0);
    step(1);
    chk("post_rst_wfr", write_from_rom, 1);
    chk("post_rst_no_done", done_t, 0);
    chk("post_rst_cur", cur_ntsc, 0);
    chk("post_rst_wfr_count", wfr_t, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/amiga_pll_reconfig_seq.md
# amiga_pll_reconfig_seq

Sequencer for PAL/NTSC switching of the Amiga clock PLL. It sits between the board-level `ntsc` select and the Altera PLL-reconfiguration core that streams scan data from the PAL/NTSC ROM images. It synchronises the mode request and drives the ROM-load, reconfig and reset handshakes with timeout and retry. It waits for PLL re-lock, then holds the downstream 7 MHz/E-clock generators off until the new clocks are stable.

## Interface
Parameters:
- `RECONF_TIMEOUT`, default 1000: `clk_in` cycles allowed for `busy` to drop after a `reconfig` pulse.
- `LOCK_TIMEOUT`, default 4096: `clk_in` cycles allowed for PLL re-lock after reconfig completes.
- `MAX_RETRIES`, default 2: retry attempts per request (used only with the retry feature).

Ports:
- `clk_in` in 1: reconfig clock, the 27 MHz board input.
- `rst` in 1: asynchronous, active-high reset.
- `ntsc` in 1: requested mode (1 = NTSC), asynchronous; synchronised internally by 2 flops.
- `pll_locked` in 1: PLL lock, asynchronous; synchronised internally by 2 flops.
- `busy` in 1: reconfig core busy.
- `write_from_rom` out 1: one-cycle pulse that starts the ROM-to-scan-chain load.
- `reconfig` out 1: one-cycle pulse that applies the scan chain.
- `reconfig_reset` out 1: one-cycle pulse that resets a stuck reconfig core.
- `rom_sel_ntsc` out 1: ROM image select, latched at request start and stable through the whole sequence.
- `cur_ntsc` out 1: mode currently programmed into the PLL.
- `sys_hold` out 1: hold request for the generated-clock logic.
- `done` out 1: one-cycle pulse when a sequence completes with lock.
- `err` out 1: sticky failure flag; cleared only by `rst` or by the next successful `done`.

## Operation
- States: IDLE, LOAD, LOAD_WAIT, WAIT_BUSY, RECONF, RUN, LOCK, FAIL.
- IDLE:
  - If `ntsc_s != cur_ntsc`, latch `rom_sel_ntsc <= ntsc_s`, pulse `write_from_rom`, go to LOAD.
  - Otherwise `sys_hold <= ~locked_s`.
- LOAD goes to LOAD_WAIT unconditionally. This is a one-cycle ROM-read latency gap.
- LOAD_WAIT goes to WAIT_BUSY.
- WAIT_BUSY: when `busy == 0`, pulse `reconfig`, load the timer with RECONF_TIMEOUT, go to RECONF.
- RECONF goes to RUN after one cycle. This lets `busy` rise.
- RUN: timer decrements every cycle.
  - If `busy == 0`: load the timer with LOCK_TIMEOUT, go to LOCK.
  - Else if the timer reaches 1: pulse `reconfig_reset`, go to FAIL.
- LOCK:
  - If `locked_s == 1`: set `cur_ntsc <= rom_sel_ntsc`, pulse `done`, clear `err`, go to IDLE.
  - Else if the timer reaches 1: go to FAIL.
- FAIL: set `err`, go to IDLE. `cur_ntsc` is unchanged, so IDLE restarts immediately if the request still differs.
- `sys_hold` is 1 in every state except IDLE.
- The timer is `$clog2(max(RECONF_TIMEOUT, LOCK_TIMEOUT)+1)` bits wide, unsigned, and never wraps. Decrement stops at 1.
- Mode change mid-sequence is ignored until IDLE. The latched `rom_sel_ntsc` is never changed mid-sequence. A request that toggles and returns before IDLE causes no second sequence.
- `busy` already high in WAIT_BUSY: the block waits indefinitely. The stuck case is covered only by the RUN timeout.

## Timing
- Reset values:
  - State IDLE.
  - `cur_ntsc = 0`: the PLL powers up with the PAL image.
  - `rom_sel_ntsc = 0`.
  - `sys_hold = 1`.
  - `write_from_rom`, `reconfig`, `reconfig_reset`, `done`, `err` all 0.
- All outputs are registered.
- `ntsc` edge to `write_from_rom` pulse: 3 cycles (2 sync stages + IDLE decision).
- `write_from_rom` to the earliest `reconfig`: 3 cycles (LOAD, LOAD_WAIT, WAIT_BUSY with `busy` low).
- `locked_s` high in LOCK gives `done` and the `cur_ntsc` update on the same edge. `sys_hold` falls 1 cycle later, in IDLE.
- `rst` asserted mid-sequence: everything returns to reset values immediately; no pulse is emitted. After release, if `ntsc` = 1, a new sequence starts 3 cycles later.

## Configuration
- `MINIMIG_PLL_RECONFIG_RETRY_EN` defined: every path into FAIL first checks a retry counter.
  - If the counter is below `MAX_RETRIES`, it increments, pulses `reconfig_reset` where RUN did not already do so, and goes to LOAD, skipping IDLE. `err` is not set.
  - The counter clears in IDLE.
  - FAIL and `err` are reached only after `MAX_RETRIES` retries.
- Not defined: no retry counter; a failure goes straight to FAIL. `MAX_RETRIES` is unused.

## Structure
- Shared package `amiga_clk_pkg`:
  - State enum `pll_seq_state_t`.
  - Default timeout constants.
- One sub-module, `amiga_sync2`, a 2-flop synchroniser. It is instantiated twice: once for `ntsc`, once for `pll_locked`.

## Test plan
- Reset with `ntsc` = 0, `locked` = 1: no pulses; `sys_hold` falls to 0 at cycle 3 after release; `cur_ntsc` stays 0.
- `ntsc` 0→1, `busy` responds 1 for 20 cycles, `locked` returns 50 cycles later:
  - `write_from_rom` pulses at +3, `reconfig` at +6.
  - `done` pulses once, `cur_ntsc` becomes 1, `err` stays 0.
- `busy` stuck at 1 after `reconfig`, retry macro off: `reconfig_reset` pulses 999 cycles after RUN entry; `err` is 1; a new sequence restarts.
- Same stimulus, retry macro on, `MAX_RETRIES` = 2: exactly 3 `write_from_rom` pulses before `err` rises.
- `ntsc` toggles 1→0 during RUN: `rom_sel_ntsc` stays 1; after `done`, a second sequence with `rom_sel_ntsc` = 0 starts 1 cycle into IDLE.
- `rst` asserted in LOCK: `sys_hold` = 1, `done` never pulses, `cur_ntsc` = 0.
